// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run/halt/step controller.
// Optional button debounce is enabled with CPU_RUN_CTRL_DEBOUNCE_EN.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_t;

    localparam int CE_COUNT_WIDTH = 32;

    function automatic logic is_active(input run_state_t s);
        return s != HALT;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_conditioner.sv
// Raw push-button to single-cycle press pulse: synchronizer, optional
// debounce (CPU_RUN_CTRL_DEBOUNCE_EN), arming flag and rising-edge detector.
module btn_conditioner
`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 100000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic press_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] fill_q;
    logic       level;
    logic       prev_q;
    logic       armed_q;
    logic       press_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;

    // Any cycle where the input agrees with the filtered level restarts the count.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // Arm only once the synchronizer holds real samples and both the raw
    // synchronized level and the filtered level read low, so a button held
    // through reset never produces a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_q | (fill_q[1] & ~sync2_q & ~level);
            press_q <= level & ~prev_q & armed_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run/halt/single-step controller: clock-enable divider, run-state FSM
// and issued-cycle counter. Button debounce via CPU_RUN_CTRL_DEBOUNCE_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIV_WIDTH-1:0]      div_i,
    input  logic                      btn_run,
    input  logic                      btn_step,
    input  logic                      cpu_halt_req,
    output logic                      cpu_ce,
    output logic [1:0]                run_state,
    output logic                      halted,
    output logic [CE_COUNT_WIDTH-1:0] ce_count
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic run_press;
    logic step_press;

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
`else
    btn_conditioner u_btn_run (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw_i(btn_run),
        .press_o  (run_press)
    );

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
`else
    btn_conditioner u_btn_step (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw_i(btn_step),
        .press_o  (step_press)
    );

    run_state_t                state_q;
    run_state_t                state_d;
    logic [DIV_WIDTH-1:0]      div_cnt_q;
    logic [DIV_WIDTH-1:0]      div_cnt_d;
    logic                      ce_q;
    logic                      ce_d;
    logic                      skip_q;
    logic                      skip_d;
    logic [CE_COUNT_WIDTH-1:0] ce_count_q;
    logic [CE_COUNT_WIDTH-1:0] ce_count_d;
    logic                      entering;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: begin
                if (run_press) begin
                    state_d = RUN;
                end else if (step_press) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (run_press || (ce_q && cpu_halt_req && !skip_q)) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                if (ce_q) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // A pulse is only launched if the machine is still active next cycle,
    // so a halt decision never leaves a trailing cpu_ce behind it.
    always_comb begin
        entering   = !is_active(state_q) && is_active(state_d);
        div_cnt_d  = div_cnt_q;
        ce_d       = 1'b0;
        skip_d     = skip_q;
        ce_count_d = ce_count_q;

        if (entering) begin
            div_cnt_d = div_i;
        end else if (is_active(state_q)) begin
            if (div_cnt_q == '0) begin
                div_cnt_d = div_i;
                ce_d      = is_active(state_d);
            end else begin
                div_cnt_d = div_cnt_q - 1'b1;
            end
        end

        if (entering) begin
            skip_d = 1'b1;
        end else if (ce_q) begin
            skip_d = 1'b0;
        end

        if (ce_q) begin
            ce_count_d = ce_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HALT;
            div_cnt_q  <= '0;
            ce_q       <= 1'b0;
            skip_q     <= 1'b0;
            ce_count_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            ce_q       <= ce_d;
            skip_q     <= skip_d;
            ce_count_q <= ce_count_d;
        end
    end

    assign cpu_ce    = ce_q;
    assign run_state = state_q;
    assign halted    = (state_q == HALT);
    assign ce_count  = ce_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the CPU core on the FPGA top level. It produces a one-cycle clock-enable pulse (`cpu_ce`) at a programmable divided rate from the board clock. It sequences the CPU between HALT, RUN and STEP, driven by two raw push-buttons and the CPU's halt request. It also counts the CPU cycles it has issued.

## Interface
Parameters:
- `DIV_WIDTH`, 16: width of the divider load value and counter.
- `DEBOUNCE_CYCLES`, 100000: cycles a synchronized button level must stay stable before it is accepted. Used only with the debounce feature.

Ports:
- `clk`  in  1  board clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `div_i`  in  DIV_WIDTH  divider value N; `cpu_ce` period is N+1 cycles.
- `btn_run`  in  1  raw, asynchronous run/stop toggle button.
- `btn_step`  in  1  raw, asynchronous single-step button.
- `cpu_halt_req`  in  1  level from the CPU; the CPU requests halt.
- `cpu_ce`  out  1  one-cycle enable for all CPU state.
- `run_state`  out  2  HALT=0, RUN=1, STEP=2.
- `halted`  out  1  high when `run_state`==HALT.
- `ce_count`  out  32  number of `cpu_ce` pulses issued; wraps 2^32-1→0.

## Operation
- Button path, per button:
  - 2-flop synchronizer, then the optional debounce filter, then a rising-edge detector giving a 1-cycle pulse.
  - An arming flag is cleared by reset. It sets once the filtered level is seen low. Edges are suppressed while the flag is clear, so a button held through reset produces no pulse.
- Divider:
  - A down-counter is loaded with `div_i` on every cycle the state enters RUN or STEP, and on every `cpu_ce`.
  - It decrements each non-HALT cycle.
  - `cpu_ce` is registered and asserts for one cycle when the counter is 0 and the state is not HALT.
  - `div_i` is sampled only at load. A mid-count change takes effect on the next period.
  - N=0 gives `cpu_ce` on every cycle.
- State machine, reset to HALT:
  - HALT: run pulse → RUN; step pulse → STEP. Run and step pulses in the same cycle → RUN. `cpu_halt_req` is ignored.
  - RUN: run pulse → HALT. `cpu_halt_req`==1 in a `cpu_ce` cycle → HALT after that pulse. Step pulses are ignored.
  - STEP: after exactly one `cpu_ce` → HALT. All button pulses are ignored.
  - Halt-skip: the first `cpu_ce` after leaving HALT ignores `cpu_halt_req`, so the CPU can execute past its halt instruction.
  - Run pulse and `cpu_halt_req`@ce in the same RUN cycle → HALT, taken once.
  - Entering HALT never truncates a `cpu_ce` pulse already asserted.
- `ce_count` increments on every `cpu_ce` cycle.

## Timing
- Reset values: `cpu_ce`=0, `run_state`=HALT, `halted`=1, `ce_count`=0. The divider counter, synchronizers, debounce counters, edge registers and arming flags are all 0.
- Assertion of `rst_n` (low) in any state takes effect at the next edge: it forces HALT and drops `cpu_ce` that same cycle. No pulse occurs during reset.
- Button latency without debounce: a raw rising edge produces the state change 4 cycles later (2 synchronizer + 1 edge + 1 state register). With debounce, add `DEBOUNCE_CYCLES`.
- First `cpu_ce` occurs N+1 cycles after `run_state` leaves HALT. Subsequent pulses are N+1 cycles apart.
- In STEP, `halted` rises on the cycle after the single `cpu_ce`.

## Configuration
- `CPU_RUN_CTRL_DEBOUNCE_EN` defined:
  - Each button has a counter of width $clog2(`DEBOUNCE_CYCLES`+1).
  - The filtered level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce back restarts the counter.
- Undefined: the filtered level is the synchronizer output, with no counters and no `DEBOUNCE_CYCLES` dependency.

## Structure
- Package `cpu_run_ctrl_pkg` holds:
  - `run_state_t`, an enum of 2 bits: HALT/RUN/STEP.
  - The `CE_COUNT_WIDTH`=32 constant.
- Sub-module `btn_conditioner`, instantiated twice. It contains the synchronizer, the optional debounce, the arming flag and the edge detector, and outputs a 1-cycle `press` pulse.
- The top contains the divider, the state machine and `ce_count`.

## Test plan
- Reset, `div_i`=3, clean `btn_run` press → `run_state`=RUN, first `cpu_ce` 4 cycles later, then every 4 cycles. After 10 pulses, `ce_count`=10.
- RUN, `div_i`=0, `cpu_halt_req` high on the 6th `cpu_ce` → exactly 6 pulses, then HALT; `halted`=1 the next cycle.
- HALT with `cpu_halt_req` held high, `btn_step` press → exactly 1 `cpu_ce` (halt-skip), then HALT, `ce_count`+1. Run press → RUN, continuing past the skipped pulse; halts at the second pulse.
- Simultaneous run and step pulses in HALT → RUN. A run press during RUN combined with `cpu_halt_req`@ce in the same cycle → single HALT, no extra pulse.
- `btn_run` held high through reset release → stays HALT. Release then press → RUN. `rst_n` low mid-RUN → `cpu_ce`=0 and state HALT at the next edge, `ce_count`=0.
- With `CPU_RUN_CTRL_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=8 → 5-cycle glitches produce no transition. A 20-cycle stable press produces exactly one transition.
